interrupt_dispatcher: RTL and testbench

//   Upstream source of the per-core interrupt trigger/PC pair consumed by the interrupt controller stage.
//   - Latches external and software interrupt requests as pending.
//   - Masks them with a per-source enable.
//   - Picks one winner by fixed priority and looks up its vector PC and target core in bus-programmable tables.
//   - Issues a one-cycle trigger for that core; blocks further dispatch to it until the core signals done.

---
 rtl/interrupt_dispatcher.sv | 154 +++++++++++++++
 tb/tb_interrupt_dispatcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_dispatcher.sv
// rtl/interrupt_dispatcher.sv - pending/enable/priority interrupt dispatcher with
// bus-programmable vector and target tables; one trigger pulse per dispatch per core.
module interrupt_dispatcher #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int NUM_CORES    = 2,
  parameter int NUM_SOURCES  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SOURCES-1:0]  i_irq_in,
  input  logic [NUM_CORES-1:0]    i_irq_done,
  input  logic                    i_cfg_write,
  input  logic                    i_cfg_read,
  input  logic [ADDRESS_BITS-1:0] i_cfg_address,
  input  logic [DATA_WIDTH-1:0]   i_cfg_data_in,
  output logic [DATA_WIDTH-1:0]   o_cfg_data_out,
  output logic [ADDRESS_BITS-1:0] o_interrupt_PC_out,
  output logic [DATA_WIDTH-1:0]   o_interrupt_trigger_out,
  output logic [NUM_CORES-1:0]    o_in_service
);

  localparam int CORE_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int SRC_BITS  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [NUM_SOURCES-1:0]  r_irq_prev;
  logic [NUM_SOURCES-1:0]  r_enable;
  logic [NUM_SOURCES-1:0]  r_pending;
  logic [ADDRESS_BITS-1:0] r_vector [NUM_SOURCES];
  logic [CORE_BITS-1:0]    r_target [NUM_SOURCES];
  logic [NUM_CORES-1:0]    r_in_service;
  logic [DATA_WIDTH-1:0]   r_cfg_data_out;
  logic [ADDRESS_BITS-1:0] r_pc_out;
  logic [CORE_BITS-1:0]    r_issue_core;

  logic [7:0]              w_addr;
  logic [NUM_SOURCES-1:0]  w_eligible;
  logic                    w_any;
  logic [SRC_BITS-1:0]     w_win;
  logic [CORE_BITS-1:0]    w_win_core;
  logic                    w_dispatch;
  logic [NUM_SOURCES-1:0]  w_set;
  logic [NUM_SOURCES-1:0]  w_clr;
  logic [NUM_SOURCES-1:0]  w_pending_next;
  logic [NUM_CORES-1:0]    w_in_service_next;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused;

  assign w_addr   = i_cfg_address[7:0];
  assign w_unused = ^{i_cfg_address[ADDRESS_BITS-1:8], i_cfg_data_in};

  // Eligibility uses only registered state, so a same-cycle irq_done takes effect next cycle.
  always_comb begin
    w_eligible = '0;
    w_any      = 1'b0;
    w_win      = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      w_eligible[s] = r_pending[s] & r_enable[s] & (int'(r_target[s]) < NUM_CORES)
                      & ~r_in_service[r_target[s]];
    end
    for (int s = NUM_SOURCES - 1; s >= 0; s--) begin
      if (w_eligible[s]) begin
        w_any = 1'b1;
        w_win = SRC_BITS'(s);
      end
    end
  end

  assign w_win_core = r_target[w_win];

  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_dispatch   = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // New set requests win over both the W1C write and the dispatch clear.
  always_comb begin
    w_set = (i_irq_in & ~r_irq_prev)
            | ((i_cfg_write && w_addr == 8'h02) ? i_cfg_data_in[NUM_SOURCES-1:0] : '0);
    w_clr = ((i_cfg_write && w_addr == 8'h01) ? i_cfg_data_in[NUM_SOURCES-1:0] : '0)
            | (w_dispatch ? (NUM_SOURCES'(1) << w_win) : '0);
    w_pending_next    = (r_pending & ~w_clr) | w_set;
    w_in_service_next = (r_in_service & ~i_irq_done)
                        | (w_dispatch ? (NUM_CORES'(1) << w_win_core) : '0);
  end

  always_comb begin
    w_rdata = '0;
    if (w_addr == 8'h00) w_rdata = DATA_WIDTH'(r_enable);
    if (w_addr == 8'h01) w_rdata = DATA_WIDTH'(r_pending);
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (w_addr == 8'(16 + s)) w_rdata = DATA_WIDTH'(r_vector[s]);
      if (w_addr == 8'(32 + s)) w_rdata = DATA_WIDTH'(r_target[s]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_prev     <= '0;
      r_enable       <= '0;
      r_pending      <= '0;
      r_in_service   <= '0;
      r_cfg_data_out <= '0;
      r_pc_out       <= '0;
      r_issue_core   <= '0;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        r_vector[s] <= '0;
        r_target[s] <= '0;
      end
    end else begin
      r_irq_prev   <= i_irq_in;
      r_pending    <= w_pending_next;
      r_in_service <= w_in_service_next;
      if (i_cfg_read) r_cfg_data_out <= w_rdata;
      if (i_cfg_write && w_addr == 8'h00) r_enable <= i_cfg_data_in[NUM_SOURCES-1:0];
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (i_cfg_write && w_addr == 8'(16 + s)) r_vector[s] <= i_cfg_data_in[ADDRESS_BITS-1:0];
        if (i_cfg_write && w_addr == 8'(32 + s)) r_target[s] <= i_cfg_data_in[CORE_BITS-1:0];
      end
      // PC and core are captured at the decision, so table writes during ISSUE cannot alter them.
      if (w_dispatch) begin
        r_pc_out     <= r_vector[w_win];
        r_issue_core <= w_win_core;
      end
    end
  end

  assign o_cfg_data_out          = r_cfg_data_out;
  assign o_interrupt_PC_out      = r_pc_out;
  assign o_in_service            = r_in_service;
  // Gated by reset so a reset landing in the ISSUE cycle suppresses the pulse.
  assign o_interrupt_trigger_out = (r_state == S_ISSUE && !reset)
                                   ? (DATA_WIDTH'(1) << r_issue_core) : '0;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb/tb_interrupt_dispatcher.sv - directed self-checking bench for interrupt_dispatcher.
module tb_interrupt_dispatcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_irq_in = '0;
  logic [1:0]  i_irq_done = '0;
  logic        i_cfg_write = 1'b0;
  logic        i_cfg_read = 1'b0;
  logic [19:0] i_cfg_address = '0;
  logic [31:0] i_cfg_data_in = '0;
  logic [31:0] o_cfg_data_out;
  logic [19:0] o_interrupt_PC_out;
  logic [31:0] o_interrupt_trigger_out;
  logic [1:0]  o_in_service;

  interrupt_dispatcher #(
    .DATA_WIDTH(32), .ADDRESS_BITS(20), .NUM_CORES(2), .NUM_SOURCES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_irq_in(i_irq_in),
    .i_irq_done(i_irq_done),
    .i_cfg_write(i_cfg_write),
    .i_cfg_read(i_cfg_read),
    .i_cfg_address(i_cfg_address),
    .i_cfg_data_in(i_cfg_data_in),
    .o_cfg_data_out(o_cfg_data_out),
    .o_interrupt_PC_out(o_interrupt_PC_out),
    .o_interrupt_trigger_out(o_interrupt_trigger_out),
    .o_in_service(o_in_service)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int trig_count = 0;
  int n0;
  int c0;
  logic [31:0] trig_hist [0:63];
  logic [31:0] pc_hist [0:63];
  int          cyc_hist [0:63];

  always @(posedge clock) cyc <= cyc + 1;

  // Every nonzero trigger sample is one recorded pulse cycle.
  always @(negedge clock) begin
    if (o_interrupt_trigger_out != 0) begin
      if (trig_count < 64) begin
        trig_hist[trig_count] = o_interrupt_trigger_out;
        pc_hist[trig_count]   = 32'(o_interrupt_PC_out);
        cyc_hist[trig_count]  = cyc;
      end
      trig_count = trig_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    i_cfg_address = 20'(addr);
    i_cfg_data_in = data;
    i_cfg_write   = 1'b1;
    tick();
    i_cfg_write   = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    i_cfg_address = 20'(addr);
    i_cfg_read    = 1'b1;
    tick();
    i_cfg_read    = 1'b0;
    check(tag, o_cfg_data_out, exp);
  endtask

  task automatic wait_count(input string tag, input int n, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (trig_count >= n) break;
      tick();
    end
    check(tag, 32'(trig_count), 32'(n));
  endtask

  task automatic pulse_done(input logic [1:0] mask);
    i_irq_done = mask;
    tick();
    i_irq_done = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_service", 32'(o_in_service), 32'h0);
    check("rst_trigger", o_interrupt_trigger_out, 32'h0);
    check("rst_pc", 32'(o_interrupt_PC_out), 32'h0);
    check("rst_data_out", o_cfg_data_out, 32'h0);
    bus_read("rst_enable", 8'h00, 32'h0);
    bus_read("rst_pending", 8'h01, 32'h0);

    // Basic dispatch of source 3 to core 1
    bus_write(8'h13, 32'h01234);
    bus_write(8'h23, 32'h1);
    bus_write(8'h00, 32'h08);
    bus_read("t1_vector_rb", 8'h13, 32'h01234);
    n0 = trig_count;
    i_irq_in[3] = 1'b1;
    c0 = cyc;
    wait_count("t1_dispatch", n0 + 1, 10);
    repeat (3) tick();
    check("t1_single_pulse", 32'(trig_count), 32'(n0 + 1));
    check("t1_trigger", trig_hist[n0], 32'h2);
    check("t1_pc", pc_hist[n0], 32'h01234);
    check("t1_latency", 32'(cyc_hist[n0] - c0), 32'd2);
    check("t1_in_service", 32'(o_in_service), 32'h2);
    check("t1_pc_hold", 32'(o_interrupt_PC_out), 32'h01234);
    check("t1_trigger_idle", o_interrupt_trigger_out, 32'h0);
    bus_read("t1_pending", 8'h01, 32'h0);
    i_irq_in[3] = 1'b0;
    pulse_done(2'b10);
    check("t1_done", 32'(o_in_service), 32'h0);

    // Priority: sources 2 and 5 both to core 0
    bus_write(8'h12, 32'h00222);
    bus_write(8'h15, 32'h00555);
    bus_write(8'h00, 32'h24);
    n0 = trig_count;
    i_irq_in[2] = 1'b1;
    i_irq_in[5] = 1'b1;
    wait_count("t2_first", n0 + 1, 10);
    repeat (6) tick();
    check("t2_blocked", 32'(trig_count), 32'(n0 + 1));
    check("t2_first_pc", pc_hist[n0], 32'h00222);
    check("t2_first_trig", trig_hist[n0], 32'h1);
    bus_read("t2_pending5", 8'h01, 32'h20);
    c0 = cyc;
    pulse_done(2'b01);
    wait_count("t2_second", n0 + 2, 10);
    check("t2_second_pc", pc_hist[n0 + 1], 32'h00555);
    check("t2_after_done", 32'(cyc_hist[n0 + 1] - c0), 32'd2);
    i_irq_in[2] = 1'b0;
    i_irq_in[5] = 1'b0;
    tick();
    pulse_done(2'b01);

    // Parallel cores
    bus_write(8'h10, 32'h00100);
    bus_write(8'h11, 32'h00101);
    bus_write(8'h21, 32'h1);
    bus_write(8'h00, 32'h03);
    n0 = trig_count;
    i_irq_in[0] = 1'b1;
    i_irq_in[1] = 1'b1;
    wait_count("t3_two", n0 + 2, 12);
    repeat (2) tick();
    check("t3_count", 32'(trig_count), 32'(n0 + 2));
    check("t3_trig0", trig_hist[n0], 32'h1);
    check("t3_pc0", pc_hist[n0], 32'h00100);
    check("t3_trig1", trig_hist[n0 + 1], 32'h2);
    check("t3_pc1", pc_hist[n0 + 1], 32'h00101);
    check("t3_spacing", 32'(cyc_hist[n0 + 1] - cyc_hist[n0]), 32'd2);
    check("t3_in_service", 32'(o_in_service), 32'h3);
    i_irq_in[0] = 1'b0;
    i_irq_in[1] = 1'b0;
    pulse_done(2'b11);
    check("t3_done", 32'(o_in_service), 32'h0);

    // Masking and W1C
    bus_write(8'h14, 32'h00444);
    bus_write(8'h00, 32'h00);
    n0 = trig_count;
    i_irq_in[4] = 1'b1;
    repeat (5) tick();
    check("t4_masked", 32'(trig_count), 32'(n0));
    bus_read("t4_pending", 8'h01, 32'h10);
    i_irq_in[4] = 1'b0;
    tick();
    i_irq_in[4] = 1'b1;
    bus_write(8'h01, 32'h10);
    bus_read("t4_set_beats_w1c", 8'h01, 32'h10);
    bus_write(8'h01, 32'h10);
    bus_read("t4_w1c", 8'h01, 32'h0);
    i_irq_in[4] = 1'b0;
    tick();
    i_irq_in[4] = 1'b1;
    tick();
    bus_read("t4_repend", 8'h01, 32'h10);
    check("t4_still_masked", 32'(trig_count), 32'(n0));
    bus_write(8'h00, 32'h10);
    wait_count("t4_dispatch", n0 + 1, 10);
    check("t4_pc", pc_hist[n0], 32'h00444);
    i_cfg_address = 20'h0;
    i_cfg_data_in = 32'h40;
    i_cfg_read    = 1'b1;
    i_cfg_write   = 1'b1;
    tick();
    i_cfg_read    = 1'b0;
    i_cfg_write   = 1'b0;
    check("t4_rw_old", o_cfg_data_out, 32'h10);
    bus_read("t4_rw_new", 8'h00, 32'h40);
    i_irq_in[4] = 1'b0;
    pulse_done(2'b01);

    // Level hold and SWTRIG
    bus_write(8'h16, 32'h00666);
    n0 = trig_count;
    i_irq_in[6] = 1'b1;
    repeat (20) tick();
    i_irq_in[6] = 1'b0;
    check("t5_level_once", 32'(trig_count), 32'(n0 + 1));
    check("t5_pc", pc_hist[n0], 32'h00666);
    bus_write(8'h02, 32'h40);
    repeat (3) tick();
    check("t5_sw_blocked", 32'(trig_count), 32'(n0 + 1));
    bus_read("t5_sw_pending", 8'h01, 32'h40);
    bus_read("t5_swtrig_reads0", 8'h02, 32'h0);
    bus_read("t5_unmapped", 8'h30, 32'h0);
    pulse_done(2'b01);
    wait_count("t5_sw_dispatch", n0 + 2, 10);
    check("t5_sw_pc", pc_hist[n0 + 1], 32'h00666);
    check("t5_sw_trig", trig_hist[n0 + 1], 32'h1);
    pulse_done(2'b01);

    // Reset landing in the ISSUE cycle
    n0 = trig_count;
    bus_write(8'h02, 32'h40);
    tick();
    reset = 1'b1;
    #1;
    check("t6_trig_abort", o_interrupt_trigger_out, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_in_service", 32'(o_in_service), 32'h0);
    check("t6_pc", 32'(o_interrupt_PC_out), 32'h0);
    check("t6_data_out", o_cfg_data_out, 32'h0);
    bus_read("t6_enable", 8'h00, 32'h0);
    bus_read("t6_pending", 8'h01, 32'h0);
    bus_read("t6_vector", 8'h16, 32'h0);
    bus_read("t6_target", 8'h21, 32'h0);
    repeat (10) tick();
    check("t6_no_dispatch", 32'(trig_count), 32'(n0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
